// File: rtl/spike_aer_arbiter.sv
// spike_aer_arbiter: collects single-cycle spike pulses from a neuron layer and
// serialises them into AER events (neuron index + optional timestep) using a
// round-robin arbiter and a valid/ready output handshake.
// Optional feature macro: AER_TIMESTAMP_EN. When it is defined, each neuron
// latches the timestep of its spike and ev_ts carries it. When it is undefined,
// no timestamp storage is built and ev_ts is tied to zero.
module spike_aer_arbiter #(
  parameter int NUM_NEURONS = 8,
  parameter int ADDR_W      = 3,
  parameter int TS_W        = 16,
  parameter int DROP_W      = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_NEURONS-1:0] spikes,
  input  logic                   tick,
  output logic                   ev_valid,
  input  logic                   ev_ready,
  output logic [ADDR_W-1:0]      ev_addr,
  output logic [TS_W-1:0]        ev_ts,
  output logic [DROP_W-1:0]      drop_cnt,
  input  logic                   drop_clr,
  output logic                   busy
);

  localparam int IDX_W = $clog2(NUM_NEURONS);
  localparam int CNT_W = $clog2(NUM_NEURONS + 1);
  localparam int SUM_W = DROP_W + CNT_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_NEURONS - 1);
  localparam logic [SUM_W-1:0]  DROP_MAX  = SUM_W'({DROP_W{1'b1}});

  typedef enum logic {S_IDLE, S_PRESENT} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [NUM_NEURONS-1:0]  r_pending;
  logic [NUM_NEURONS-1:0]  w_pending_nxt;
  logic [NUM_NEURONS-1:0]  w_hit;
  logic [TS_W-1:0]         r_ts_cnt;
  logic [ADDR_W-1:0]       r_rr_ptr;
  logic [ADDR_W-1:0]       r_ev_addr;
  logic [DROP_W-1:0]       r_drop_cnt;
  logic [DROP_W-1:0]       w_drop_nxt;
  logic [SUM_W-1:0]        w_drop_sum;
  logic [CNT_W-1:0]        w_ndrop;
  logic                    w_found;
  logic [ADDR_W-1:0]       w_sel;
  logic                    w_load;
  logic                    w_accept;

  // Round-robin search: first pending neuron at or above rr_ptr, wrapping.
  always_comb begin
    int idx;
    idx     = 0;
    w_found = 1'b0;
    w_sel   = '0;
    for (int k = 0; k < NUM_NEURONS; k++) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NUM_NEURONS) idx = idx - NUM_NEURONS;
      if (!w_found && r_pending[IDX_W'(idx)]) begin
        w_found = 1'b1;
        w_sel   = ADDR_W'(idx);
      end
    end
  end

  // FSM next state: IDLE loads a winner, PRESENT waits for the handshake.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_load      = 1'b1;
          w_state_nxt = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (ev_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
    endcase
  end

  // Pending capture: a spike on a neuron whose event is being accepted on this
  // edge re-arms it instead of being counted as a drop.
  always_comb begin
    w_pending_nxt = r_pending;
    w_ndrop       = '0;
    w_hit         = '0;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      w_hit[i] = w_accept && (r_ev_addr == ADDR_W'(i));
      if (spikes[i]) begin
        if (r_pending[i] && !w_hit[i]) w_ndrop = w_ndrop + CNT_W'(1);
        else                           w_pending_nxt[i] = 1'b1;
      end else if (w_hit[i]) begin
        w_pending_nxt[i] = 1'b0;
      end
    end
  end

  // Saturating drop count; a clear in the same cycle keeps this cycle's drops.
  always_comb begin
    w_drop_sum = (drop_clr ? '0 : SUM_W'(r_drop_cnt)) + SUM_W'(w_ndrop);
    w_drop_nxt = (w_drop_sum > DROP_MAX) ? {DROP_W{1'b1}} : w_drop_sum[DROP_W-1:0];
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Control state: pending set, timestep counter, round-robin pointer, drops,
  // and the presented event address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pending  <= '0;
      r_ts_cnt   <= '0;
      r_rr_ptr   <= '0;
      r_drop_cnt <= '0;
      r_ev_addr  <= '0;
    end else begin
      r_pending  <= w_pending_nxt;
      r_ts_cnt   <= r_ts_cnt + {{(TS_W-1){1'b0}}, tick};
      r_drop_cnt <= w_drop_nxt;
      if (w_load)   r_ev_addr <= w_sel;
      if (w_accept) r_rr_ptr  <= (r_ev_addr == LAST_ADDR) ? '0 : r_ev_addr + 1'b1;
    end
  end

`ifdef AER_TIMESTAMP_EN
  logic [TS_W-1:0]        r_ts_lat [NUM_NEURONS];
  logic [TS_W-1:0]        r_ev_ts;
  logic [NUM_NEURONS-1:0] w_capture;
  logic [IDX_W-1:0]       w_sel_idx;

  assign w_capture = spikes & (~r_pending | w_hit);
  assign w_sel_idx = IDX_W'(w_sel);

  // Per-neuron timestep latch, loaded with the pre-increment counter value.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_NEURONS; i++) begin
      if (w_capture[i]) r_ts_lat[i] <= r_ts_cnt;
    end
  end

  // Presented timestamp, captured together with the winning address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      r_ev_ts <= '0;
    else if (w_load) r_ev_ts <= r_ts_lat[w_sel_idx];
  end

  assign ev_ts = r_ev_ts;
`else
  assign ev_ts = '0;
`endif

  assign ev_valid = (r_state == S_PRESENT);
  assign ev_addr  = r_ev_addr;
  assign drop_cnt = r_drop_cnt;
  assign busy     = (|r_pending) | ev_valid;

endmodule
